ad7266_emulator: RTL and testbench

Synthesizable SPI-target model of the AD7266 dual 12-bit ADC, the responder end of the AD7266 serial interface. It receives SCLK/CSn from an AD7266 controller, oversamples them in the clk_in domain, and shifts out two simultaneous data streams (DOUTA/DOUTB) framed like the real part. Used for on-board loopback of the ADC controller and as the ADC stand-in in system simulation.

---
 rtl/ad7266_pkg.sv | 23 ++
 rtl/ad7266_emulator_sync_edge.sv | 31 +++
 rtl/ad7266_emulator.sv | 152 +++++++++++++++
 tb/tb_ad7266_emulator.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/ad7266_pkg.sv
// rtl/ad7266_pkg.sv - AD7266 frame constants, state encoding and frame-word builder
package ad7266_pkg;

  localparam int FRAME_BITS  = 16;
  localparam int LEAD_ZEROS  = 2;
  localparam int DATA_BITS   = 12;
  localparam int TRAIL_ZEROS = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Differential mode is two's complement: flipping the MSB of the offset-binary sample
  function automatic logic [FRAME_BITS-1:0] frame_word(input logic [DATA_BITS-1:0] sample,
                                                        input logic sgl);
    logic [DATA_BITS-1:0] code;
    code = sgl ? sample : {~sample[DATA_BITS-1], sample[DATA_BITS-2:0]};
    return {{LEAD_ZEROS{1'b0}}, code, {TRAIL_ZEROS{1'b0}}};
  endfunction

endpackage

// File: rtl/ad7266_emulator_sync_edge.sv
// rtl/ad7266_emulator_sync_edge.sv - multi-flop synchronizer with rise/fall strobes
module sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic d_in,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Shift the asynchronous pin through the synchronizer chain, then keep one history flop
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Strobes are decoded from the last sync stage so the consumer registers on the same edge
  assign rise_o =  sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[SYNC_STAGES-1] &  prev_q;

endmodule

// File: rtl/ad7266_emulator.sv
// rtl/ad7266_emulator.sv - AD7266 dual-ADC serial responder model
module ad7266_emulator
  import ad7266_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                 rst_in,
  input  logic                 clk_in,
  input  logic [DATA_BITS-1:0] sample_a_in,
  input  logic [DATA_BITS-1:0] sample_b_in,
  input  logic [2:0]           addr_in,
  input  logic                 sgl_in,
  input  logic                 sclk_in,
  input  logic                 csn_in,
  output logic                 douta_out,
  output logic                 doutb_out,
  output logic                 dout_en_out,
  output logic                 busy_out,
  output logic                 frame_done_out,
  output logic                 frame_abort_out,
  output logic [2:0]           frame_addr_out
);

  localparam logic [4:0] LAST_BIT = 5'(FRAME_BITS - 1);

  logic sclk_fall, csn_rise, csn_fall;

  state_e                state_q, state_d;
  logic [FRAME_BITS-1:0] sh_a_q, sh_a_d, sh_b_q, sh_b_d;
  logic [4:0]            bit_cnt_q, bit_cnt_d;
  logic                  douta_q, douta_d, doutb_q, doutb_d;
  logic                  en_q, en_d, busy_q, busy_d;
  logic                  done_q, done_d, abort_q, abort_d;
  logic [2:0]            addr_q, addr_d;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sclk_sync (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .d_in   (sclk_in),
    .rise_o (),
    .fall_o (sclk_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_csn_sync (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .d_in   (csn_in),
    .rise_o (csn_rise),
    .fall_o (csn_fall)
  );

  // Frame sequencing: load on CSn fall, shift on SCLK fall, finish or abort on CSn rise
  always_comb begin
    state_d   = state_q;
    sh_a_d    = sh_a_q;
    sh_b_d    = sh_b_q;
    bit_cnt_d = bit_cnt_q;
    douta_d   = douta_q;
    doutb_d   = doutb_q;
    en_d      = en_q;
    busy_d    = busy_q;
    addr_d    = addr_q;
    done_d    = 1'b0;
    abort_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (csn_fall) begin
          sh_a_d    = frame_word(sample_a_in, sgl_in);
          sh_b_d    = frame_word(sample_b_in, sgl_in);
          addr_d    = addr_in;
          bit_cnt_d = 5'd0;
          en_d      = 1'b1;
          busy_d    = 1'b1;
          douta_d   = sh_a_d[FRAME_BITS-1];
          doutb_d   = sh_b_d[FRAME_BITS-1];
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (sclk_fall) begin
          bit_cnt_d = bit_cnt_q + 5'd1;
          sh_a_d    = {sh_a_q[FRAME_BITS-2:0], 1'b0};
          sh_b_d    = {sh_b_q[FRAME_BITS-2:0], 1'b0};
          if (bit_cnt_q == LAST_BIT) begin
            // A CSn rise on the same cycle as the last fall completes the frame, not aborts it
            en_d    = 1'b0;
            douta_d = 1'b0;
            doutb_d = 1'b0;
            done_d  = 1'b1;
            busy_d  = ~csn_rise;
            state_d = csn_rise ? ST_IDLE : ST_DONE;
          end else begin
            douta_d = sh_a_q[FRAME_BITS-2];
            doutb_d = sh_b_q[FRAME_BITS-2];
          end
        end else if (csn_rise) begin
          abort_d = 1'b1;
          en_d    = 1'b0;
          douta_d = 1'b0;
          doutb_d = 1'b0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_DONE: begin
        if (csn_rise) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; every output is driven straight from a flop
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= ST_IDLE;
      sh_a_q    <= '0;
      sh_b_q    <= '0;
      bit_cnt_q <= '0;
      douta_q   <= 1'b0;
      doutb_q   <= 1'b0;
      en_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
      addr_q    <= '0;
    end else begin
      state_q   <= state_d;
      sh_a_q    <= sh_a_d;
      sh_b_q    <= sh_b_d;
      bit_cnt_q <= bit_cnt_d;
      douta_q   <= douta_d;
      doutb_q   <= doutb_d;
      en_q      <= en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      abort_q   <= abort_d;
      addr_q    <= addr_d;
    end
  end

  assign douta_out       = douta_q;
  assign doutb_out       = doutb_q;
  assign dout_en_out     = en_q;
  assign busy_out        = busy_q;
  assign frame_done_out  = done_q;
  assign frame_abort_out = abort_q;
  assign frame_addr_out  = addr_q;

endmodule

// File: tb/tb_ad7266_emulator.sv
// tb/tb_ad7266_emulator.sv - directed scoreboard bench for ad7266_emulator
module tb_ad7266_emulator;

  logic        rst_in = 1'b1;
  logic        clk_in = 1'b0;
  logic [11:0] sample_a_in = '0;
  logic [11:0] sample_b_in = '0;
  logic [2:0]  addr_in = '0;
  logic        sgl_in = 1'b1;
  logic        sclk_in = 1'b1;
  logic        csn_in = 1'b1;
  logic        douta_out, doutb_out, dout_en_out, busy_out;
  logic        frame_done_out, frame_abort_out;
  logic [2:0]  frame_addr_out;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int abort_cnt = 0;
  logic [1:0] exp_q[$];

  ad7266_emulator #(.SYNC_STAGES(2)) dut (
    .rst_in          (rst_in),
    .clk_in          (clk_in),
    .sample_a_in     (sample_a_in),
    .sample_b_in     (sample_b_in),
    .addr_in         (addr_in),
    .sgl_in          (sgl_in),
    .sclk_in         (sclk_in),
    .csn_in          (csn_in),
    .douta_out       (douta_out),
    .doutb_out       (doutb_out),
    .dout_en_out     (dout_en_out),
    .busy_out        (busy_out),
    .frame_done_out  (frame_done_out),
    .frame_abort_out (frame_abort_out),
    .frame_addr_out  (frame_addr_out)
  );

  always #5 clk_in = ~clk_in;

  // Pulse counters: a pulse wider than one cycle shows up as an extra count
  always @(posedge clk_in) begin
    if (frame_done_out)  done_cnt  <= done_cnt + 1;
    if (frame_abort_out) abort_cnt <= abort_cnt + 1;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  function automatic logic [15:0] model_word(input logic [11:0] s, input logic sg);
    logic [11:0] c;
    c = sg ? s : {~s[11], s[10:0]};
    return {2'b00, c, 2'b00};
  endfunction

  // One frame: nfall SCLK falling edges, optional mid-frame input change, abort or reset point
  task automatic do_frame(input logic [11:0] sa, input logic [11:0] sb, input logic [2:0] ad,
                          input logic sg, input int nfall, input bit change_mid, input int rst_at);
    logic [15:0] wa, wb;
    logic [1:0]  e;
    int d0, a0;
    sample_a_in = sa; sample_b_in = sb; addr_in = ad; sgl_in = sg;
    wait_clks(2);
    d0 = done_cnt; a0 = abort_cnt;
    wa = model_word(sa, sg);
    wb = model_word(sb, sg);
    csn_in = 1'b0;
    for (int i = 0; i < 16; i++) exp_q.push_back({wa[15-i], wb[15-i]});
    wait_clks(5);
    check("busy_start", 32'(busy_out), 32'd1);
    check("en_start", 32'(dout_en_out), 32'd1);
    check("addr_capture", 32'(frame_addr_out), 32'(ad));
    for (int i = 0; i < nfall; i++) begin
      if (i == rst_at) begin
        rst_in = 1'b1;
        #1;
        check("rst_outs", {26'd0, douta_out, doutb_out, dout_en_out, busy_out,
                           frame_done_out, frame_abort_out}, 32'd0);
        check("rst_addr", 32'(frame_addr_out), 32'd0);
        wait_clks(2);
        csn_in = 1'b1;
        wait_clks(2);
        rst_in = 1'b0;
        wait_clks(4);
        check("rst_no_pulse", 32'(done_cnt - d0 + abort_cnt - a0), 32'd0);
        exp_q.delete();
        return;
      end
      if (i < 16) begin
        e = exp_q.pop_front();
        check($sformatf("douta_bit%0d", i), 32'(douta_out), 32'(e[1]));
        check($sformatf("doutb_bit%0d", i), 32'(doutb_out), 32'(e[0]));
      end else begin
        check("extra_en", 32'(dout_en_out), 32'd0);
        check("extra_dout", {30'd0, douta_out, doutb_out}, 32'd0);
      end
      if (change_mid && i == 8) begin
        sample_a_in = ~sa; sample_b_in = ~sb; addr_in = 3'b010; sgl_in = ~sg;
      end
      sclk_in = 1'b0;
      wait_clks(5);
      sclk_in = 1'b1;
      wait_clks(5);
    end
    if (nfall < 16) begin
      csn_in = 1'b1;
      wait_clks(6);
      check("abort_pulse", 32'(abort_cnt - a0), 32'd1);
      check("abort_no_done", 32'(done_cnt - d0), 32'd0);
      check("abort_en", 32'(dout_en_out), 32'd0);
      check("abort_busy", 32'(busy_out), 32'd0);
      exp_q.delete();
    end else begin
      check("done_pulse", 32'(done_cnt - d0), 32'd1);
      check("done_en", 32'(dout_en_out), 32'd0);
      check("done_dout", {30'd0, douta_out, doutb_out}, 32'd0);
      check("done_busy_held", 32'(busy_out), 32'd1);
      check("done_addr", 32'(frame_addr_out), 32'(ad));
      csn_in = 1'b1;
      wait_clks(6);
      check("idle_busy", 32'(busy_out), 32'd0);
      check("no_abort", 32'(abort_cnt - a0), 32'd0);
    end
  endtask

  initial begin
    wait_clks(3);
    check("reset_outs", {26'd0, douta_out, doutb_out, dout_en_out, busy_out,
                         frame_done_out, frame_abort_out}, 32'd0);
    check("reset_addr", 32'(frame_addr_out), 32'd0);
    rst_in = 1'b0;
    wait_clks(5);

    do_frame(12'hABC, 12'h123, 3'd1, 1'b1, 16, 1'b0, -1);
    do_frame(12'h000, 12'hFFF, 3'd2, 1'b0, 16, 1'b0, -1);
    do_frame(12'h5A5, 12'hC3C, 3'd3, 1'b1, 7,  1'b0, -1);
    do_frame(12'h9D2, 12'h471, 3'd4, 1'b1, 16, 1'b0, -1);
    do_frame(12'h321, 12'hDEF, 3'b101, 1'b1, 16, 1'b1, -1);
    do_frame(12'h7E1, 12'h18F, 3'd6, 1'b0, 20, 1'b0, -1);
    do_frame(12'hF0F, 12'h0F0, 3'd7, 1'b1, 16, 1'b0, 9);
    do_frame(12'hA5A, 12'h5A5, 3'd0, 1'b1, 16, 1'b0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
